// File: rtl/mmu_select.sv
// mmu_select: dwells DWELL cycles on one input channel, then steps sequentially (D_OFF=0)
// or jumps pseudo-randomly (D_OFF=1). Build macro MMU_SKIP_INVALID_EN makes sequential stepping skip invalid channels.
module mmu_select #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 64,
   parameter int DWELL = 10000000,
   localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                  D_CLK,
   input  logic                  D_RST_N,
   input  logic                  D_OFF,
   input  logic [N_CH*WIDTH-1:0] IN,
   input  logic [N_CH-1:0]       IN_VALID,
   output logic [WIDTH-1:0]      OUT,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [IDX_W-1:0]      CUR_IDX,
   output logic                  SWITCH,
   output logic [N_CH-2:0]       LED
);

   // Handshake: OUT/OUT_VALID is a one-deep valid/ready stage. A word transfers on a
   // D_CLK edge where OUT_VALID=1 and OUT_READY=1; while OUT_VALID=1 and OUT_READY=0
   // the stage holds its word and the dwell counter freezes.

   localparam int               CNT_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
   localparam logic [15:0]      LFSR_SEED = 16'hACE1;

   typedef enum logic {
      SEQ = 1'b0,
      RND = 1'b1
   } mode_t;

   mode_t            state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
   logic [IDX_W-1:0] seq_idx;
   logic [IDX_W-1:0] rnd_raw, rnd_idx;
   logic [N_CH-2:0]  led_q, led_d;
   logic             switch_q, switch_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic [WIDTH-1:0] out_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] sel_word;
   logic             sel_valid;
   logic             stall;
   logic             boundary;
`ifdef MMU_SKIP_INVALID_EN
   logic [IDX_W-1:0] skip_cand;
   logic             skip_found;
`endif

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
      if (idx == IDX_W'(N_CH - 1)) begin
         return '0;
      end
      return idx + IDX_W'(1);
   endfunction

   assign stall     = out_valid_q & ~OUT_READY;
   assign boundary  = ~stall & (cnt_q == CNT_LAST);
   assign sel_word  = IN[int'(cur_idx_q)*WIDTH +: WIDTH];
   assign sel_valid = IN_VALID[cur_idx_q];

   // Maximal-length x^16+x^14+x^13+x^11+1; free-running so stalls still stir it.
   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   // Fold the upper half of the LFSR code space back into range.
   always_comb begin
      rnd_raw = lfsr_q[IDX_W-1:0];
      rnd_idx = rnd_raw;
      if (int'(rnd_raw) >= N_CH) begin
         rnd_idx = rnd_raw - IDX_W'(N_CH);
      end
   end

   always_comb begin
      seq_idx = wrap_inc(cur_idx_q);
`ifdef MMU_SKIP_INVALID_EN
      skip_found = 1'b0;
      skip_cand  = cur_idx_q;
      for (int i = 0; i < N_CH; i++) begin
         skip_cand = wrap_inc(skip_cand);
         if (!skip_found && IN_VALID[skip_cand]) begin
            seq_idx    = skip_cand;
            skip_found = 1'b1;
         end
      end
`endif
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cur_idx_d = cur_idx_q;
      switch_d  = 1'b0;
      if (boundary) begin
         cnt_d    = '0;
         switch_d = 1'b1;
         state_d  = D_OFF ? RND : SEQ;
         if (D_OFF) begin
            cur_idx_d = rnd_idx;
         end else if (state_q == RND) begin
            cur_idx_d = '0;
         end else begin
            cur_idx_d = seq_idx;
         end
      end else if (!stall) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      led_d = '0;
      for (int k = 0; k < N_CH - 1; k++) begin
         led_d[k] = (int'(cur_idx_d) > k);
      end
   end

   always_ff @(posedge D_CLK or negedge D_RST_N) begin
      if (!D_RST_N) begin
         state_q   <= SEQ;
         cnt_q     <= '0;
         cur_idx_q <= '0;
         led_q     <= '0;
         switch_q  <= 1'b0;
         lfsr_q    <= LFSR_SEED;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cur_idx_q <= cur_idx_d;
         led_q     <= led_d;
         switch_q  <= switch_d;
         lfsr_q    <= lfsr_d;
      end
   end

   always_ff @(posedge D_CLK or negedge D_RST_N) begin
      if (!D_RST_N) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (!out_valid_q || OUT_READY) begin
         out_q       <= sel_word;
         out_valid_q <= sel_valid;
      end
   end

   assign OUT       = out_q;
   assign OUT_VALID = out_valid_q;
   assign CUR_IDX   = cur_idx_q;
   assign SWITCH    = switch_q;
   assign LED       = led_q;

endmodule

// File: tb/tb_mmu_select.sv
// tb_mmu_select: randomized and directed stimulus for mmu_select, checked against a
// cycle-level reference model through expectation queues.
module tb_mmu_select;

   localparam int N_CH  = 4;
   localparam int WIDTH = 64;
   localparam int DWELL = 4;
   localparam int IDX_W = 2;
   localparam int CTL_W = IDX_W + (N_CH - 1) + 2 + WIDTH;

   logic                  D_CLK     = 1'b0;
   logic                  D_RST_N   = 1'b0;
   logic                  D_OFF     = 1'b0;
   logic [N_CH*WIDTH-1:0] IN        = '0;
   logic [N_CH-1:0]       IN_VALID  = '0;
   logic                  OUT_READY = 1'b1;
   logic [WIDTH-1:0]      OUT;
   logic                  OUT_VALID;
   logic [IDX_W-1:0]      CUR_IDX;
   logic                  SWITCH;
   logic [N_CH-2:0]       LED;

   mmu_select #(.N_CH(N_CH), .WIDTH(WIDTH), .DWELL(DWELL)) dut (
      .D_CLK(D_CLK), .D_RST_N(D_RST_N), .D_OFF(D_OFF), .IN(IN), .IN_VALID(IN_VALID),
      .OUT(OUT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .CUR_IDX(CUR_IDX),
      .SWITCH(SWITCH), .LED(LED)
   );

   // ---------------- clock / reset ----------------
   always #5 D_CLK = ~D_CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic [CTL_W-1:0] exp_ctl_q[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail_note(input string name, input string msg);
      n_checks++;
      $display("FAIL %s: %s", name, msg);
   endtask

   // ---------------- reference model ----------------
   int          m_idx, m_cnt, m_mode;
   bit          m_sw, m_ov, m_started;
   logic [15:0] m_lfsr;
   logic [WIDTH-1:0] m_out;

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      int taps[4] = '{16, 14, 13, 11};
      logic fb = 1'b0;
      foreach (taps[t]) fb ^= l[taps[t]-1];
      return {l[14:0], fb};
   endfunction

   function automatic int rnd_pick(input logic [15:0] l);
      int r = int'(l) % (1 << IDX_W);
      if (r >= N_CH) r -= N_CH;
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] word_of(input int k);
      return IN[k*WIDTH +: WIDTH];
   endfunction

   function automatic int next_seq(input int idx);
`ifdef MMU_SKIP_INVALID_EN
      for (int i = 1; i <= N_CH; i++) begin
         if (IN_VALID[(idx + i) % N_CH]) return (idx + i) % N_CH;
      end
`endif
      return (idx + 1) % N_CH;
   endfunction

   function automatic logic [CTL_W-1:0] ctl_exp();
      logic [N_CH-2:0] led;
      led = (N_CH-1)'((1 << m_idx) - 1);
      return {IDX_W'(m_idx), led, m_sw, m_ov, m_out};
   endfunction

   task automatic model_reset();
      m_idx = 0; m_cnt = 0; m_mode = 0; m_sw = 0; m_ov = 0;
      m_lfsr = 16'hACE1; m_out = '0;
   endtask

   task automatic model_step();
      bit stall, nov;
      stall = m_ov && !OUT_READY;
      m_sw  = 0;
      if (!stall) begin
         nov   = IN_VALID[m_idx];
         m_out = word_of(m_idx);
         if (nov) exp_q.push_back(word_of(m_idx));
         if (m_cnt == DWELL - 1) begin
            m_cnt = 0;
            m_sw  = 1;
            if (D_OFF) m_idx = rnd_pick(m_lfsr);
            else if (m_mode == 1) m_idx = 0;
            else m_idx = next_seq(m_idx);
            m_mode = int'(D_OFF);
         end else begin
            m_cnt++;
         end
         m_ov = nov;
      end
      m_lfsr = lfsr_next(m_lfsr);
   endtask

   initial begin
      model_reset();
      m_started = 0;
      forever begin
         @(posedge D_CLK or negedge D_RST_N);
         if (!D_RST_N) begin
            model_reset();
            exp_q.delete();
            exp_ctl_q.delete();
         end else begin
            model_step();
         end
         exp_ctl_q.push_back(ctl_exp());
         m_started = 1;
      end
   end

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge D_CLK);
         if (exp_ctl_q.size() > 0) check("ctl", {CUR_IDX, LED, SWITCH, OUT_VALID, OUT}, exp_ctl_q.pop_front());
         else if (m_started) fail_note("ctl_underflow", "no expected control value");
         if (OUT_VALID && OUT_READY) begin
            if (exp_q.size() > 0) check("word", OUT, exp_q.pop_front());
            else fail_note("word_underflow", "DUT presented a word that was not expected");
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge D_CLK);
         #3;
      end
   endtask

   task automatic do_reset(input logic off);
      D_OFF   = off;
      D_RST_N = 1'b0;
      cyc(2);
      D_RST_N = 1'b1;
   endtask

   task automatic load_pattern();
      for (int k = 0; k < N_CH; k++) IN[k*WIDTH +: WIDTH] = 64'h1111 * (k + 1);
   endtask

   task automatic wait_switch(input string name, input int budget);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         cyc();
         if (SWITCH) begin
            ok = 1;
            break;
         end
      end
      if (!ok) fail_note(name, "timed out waiting for SWITCH");
   endtask

   task automatic wait_switch_to(input string name, input int idx, input int budget);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         cyc();
         if (SWITCH && int'(CUR_IDX) == idx) begin
            ok = 1;
            break;
         end
      end
      if (!ok) fail_note(name, "timed out waiting for channel");
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_idx"}, CUR_IDX, 0);
      check({tag, "_led"}, LED, 0);
      check({tag, "_sw"}, SWITCH, 0);
      check({tag, "_ov"}, OUT_VALID, 0);
      check({tag, "_out"}, OUT, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          exp_idx[4] = '{1, 2, 3, 0};
      logic [2:0]  exp_led[4] = '{3'b001, 3'b011, 3'b111, 3'b000};
      int          sw_n, n;
      logic [15:0] l;
      int          skip_seq[3];

      load_pattern();
      IN_VALID  = '1;
      OUT_READY = 1'b1;
      cyc(2);
      check_zero_outputs("reset");
      D_RST_N = 1'b1;

      // Sequential walk: four switches, one every DWELL cycles
      sw_n = 0;
      for (int i = 1; i <= 16; i++) begin
         cyc();
         if (SWITCH && sw_n < 4) begin
            check("seq_idx", CUR_IDX, exp_idx[sw_n]);
            check("seq_led", LED, exp_led[sw_n]);
            sw_n++;
            check("seq_spacing", i, 4 * sw_n);
         end
      end
      check("seq_switch_count", sw_n, 4);

      // Back-pressure on channel 1 stretches its dwell to 10 cycles
      wait_switch_to("stall_wait", 1, 20);
      n = 1;
      cyc();
      if (CUR_IDX == 1) n++;
      OUT_READY = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         if (CUR_IDX == 1) n++;
      end
      OUT_READY = 1'b1;
      for (int i = 0; i < 20 && CUR_IDX == 1; i++) begin
         cyc();
         if (CUR_IDX == 1) n++;
      end
      check("stall_dwell", n, 10);

      // D_OFF pulse inside a dwell must not change the mode
      wait_switch_to("toggle_wait", 3, 20);
      cyc();
      D_OFF = 1'b1;
      cyc();
      D_OFF = 1'b0;
      wait_switch("toggle_switch", 10);
      check("toggle_idx", CUR_IDX, 0);

      // Random mode from reset
      for (int k = 0; k < N_CH; k++) IN[k*WIDTH +: WIDTH] = {$urandom, $urandom};
      cyc();
      do_reset(1'b1);
      wait_switch("rnd_first", 10);
      l = 16'hACE1;
      repeat (DWELL - 1) l = lfsr_next(l);
      check("rnd_first_idx", CUR_IDX, rnd_pick(l));
      for (int i = 0; i < 30; i++) begin
         OUT_READY = 1'($urandom_range(0, 1));
         cyc();
      end
      OUT_READY = 1'b1;
      D_OFF     = 1'b0;
      cyc();
      if (!SWITCH) wait_switch("rnd_exit", 60);
      check("rnd_exit_idx", CUR_IDX, 0);

      // Asynchronous reset at count 2 on channel 2
      load_pattern();
      do_reset(1'b0);
      wait_switch_to("arst_wait", 2, 20);
      cyc(2);
      D_RST_N = 1'b0;
      #1;
      check_zero_outputs("arst");
      cyc(2);
      D_RST_N = 1'b1;
      n = 1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (CUR_IDX != 0) break;
         n++;
      end
      check("arst_dwell", n, 4);

      // Sparse valid pattern
      IN_VALID = 4'b1001;
      do_reset(1'b0);
`ifdef MMU_SKIP_INVALID_EN
      skip_seq = '{3, 0, 3};
`else
      skip_seq = '{1, 2, 3};
`endif
      for (int i = 0; i < 3; i++) begin
         wait_switch("skip_wait", 10);
         check("skip_idx", CUR_IDX, skip_seq[i]);
      end

      // Free-running random traffic
      for (int c = 0; c < 300; c++) begin
         OUT_READY = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) D_OFF = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) IN_VALID = N_CH'($urandom);
         for (int k = 0; k < N_CH; k++) begin
            if ($urandom_range(0, 1) == 1) IN[k*WIDTH +: WIDTH] = {$urandom, $urandom};
         end
         cyc();
      end

      OUT_READY = 1'b1;
      cyc(3);
      @(negedge D_CLK);
      #1;
      check("word_queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
